rtc_spi_responder: RTL



---
 rtl/rtc_spi_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rtc_spi_responder.sv
// rtc_spi_responder: SPI target serving the cartridge RTC register file (command byte, ready handshake, data bytes)
// Ports:
//   SClk, nReset            system clock, asynchronous active-low reset
//   SPIClk, nSel, SPIDi     SPI pins from the initiator (oversampled on SClk)
//   SPIDo                   MISO, updated after falling SPIClk
//   MCUReady                high = busy/idle, falls when the data phase may start
//   RegWrite/RegAddr/RegWData  one-cycle strobe describing a committed register write
//   Status                  register 0, mirrored combinationally
module rtc_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int READY_DELAY = 16
) (
    input  logic       SClk,
    input  logic       nReset,
    input  logic       SPIClk,
    input  logic       nSel,
    input  logic       SPIDi,
    output logic       SPIDo,
    output logic       MCUReady,
    output logic       RegWrite,
    output logic [3:0] RegAddr,
    output logic [7:0] RegWData,
    output logic [7:0] Status
);
    localparam int DW = $clog2(READY_DELAY + 2);
    typedef enum logic [2:0] {IDLE, CMD, DELAY, DATA, DONE, IGNORE} state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] clk_sync, sel_sync, di_sync;
    logic          sclk_s, sel_s, di_s, sclk_d, sel_d;
    logic          rise, fall, sel_fall, sel_rise;
    logic [7:0]    regs [10];
    logic [7:0]    shreg, oshift, byte_in, ld;
    logic [3:0]    cmd, addr, base, rd_addr;
    logic [2:0]    op, bit_cnt, left, nbytes;
    logic [DW-1:0] dly;
    logic          rd, is_nop, is_rst, cmd_ok;

    function automatic logic [7:0] dflt(input int i);
        return (i == 2 || i == 3) ? 8'h01 : 8'h00;
    endfunction

    assign sclk_s   = clk_sync[SYNC_STAGES-1];
    assign sel_s    = sel_sync[SYNC_STAGES-1];
    assign di_s     = di_sync[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_d;
    assign fall     = ~sclk_s & sclk_d;
    assign sel_fall = ~sel_s & sel_d;
    assign sel_rise = sel_s & ~sel_d;
    assign byte_in  = {shreg[6:0], di_s};
    assign cmd_ok   = byte_in[7:4] == 4'hF && byte_in[3:1] < 3'd6;
    assign op       = cmd[3:1];
    assign rd       = cmd[0];
    assign is_nop   = op == 3'd5;
    assign is_rst   = op == 3'd0;
    assign base     = op == 3'd2 ? 4'd1 : op == 3'd3 ? 4'd5 : op == 3'd4 ? 4'd8 : 4'd0;
    assign nbytes   = op == 3'd1 ? 3'd1 : op == 3'd2 ? 3'd7 : op == 3'd3 ? 3'd3 :
                      (op == 3'd4 || op == 3'd5) ? 3'd2 : 3'd0;
    // The first byte is preloaded from the command's base address; later bytes from the running address.
    assign rd_addr  = state == DELAY ? base : addr;
    assign ld       = !rd ? 8'hFF : (is_nop || rd_addr > 4'd9) ? 8'h00 : regs[rd_addr];
    assign Status   = regs[0];

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            clk_sync <= '0;
            sel_sync <= '1;
            di_sync  <= '0;
            sclk_d   <= 1'b0;
            sel_d    <= 1'b1;
        end else begin
            clk_sync <= SYNC_STAGES'({clk_sync, SPIClk});
            sel_sync <= SYNC_STAGES'({sel_sync, nSel});
            di_sync  <= SYNC_STAGES'({di_sync, SPIDi});
            sclk_d   <= sclk_s;
            sel_d    <= sel_s;
        end
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_fall) state_nxt = CMD;
            CMD:     if (rise && bit_cnt == 3'd7) state_nxt = cmd_ok ? DELAY : IGNORE;
            DELAY:   if (dly == '0) state_nxt = is_rst ? DONE : DATA;
            DATA:    if (rise && bit_cnt == 3'd7 && left == 3'd1) state_nxt = DONE;
            default: ;
        endcase
        // Deselect wins over everything, but only after the current edge has been processed.
        if (sel_rise) state_nxt = IDLE;
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            SPIDo    <= 1'b1;
            MCUReady <= 1'b1;
            RegWrite <= 1'b0;
            RegAddr  <= 4'd0;
            RegWData <= 8'd0;
            shreg    <= 8'd0;
            oshift   <= 8'hFF;
            cmd      <= 4'd0;
            addr     <= 4'd0;
            left     <= 3'd0;
            bit_cnt  <= 3'd0;
            dly      <= '0;
            for (int i = 0; i < 10; i++) regs[i] <= dflt(i);
        end else begin
            RegWrite <= 1'b0;
            case (state)
                CMD: if (rise) begin
                    shreg   <= byte_in;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        cmd <= byte_in[3:0];
                        dly <= DW'(READY_DELAY);
                    end
                end
                DELAY: if (dly != '0) dly <= dly - DW'(1);
                else begin
                    MCUReady <= 1'b0;
                    addr     <= base;
                    left     <= nbytes;
                    oshift   <= ld;
                    SPIDo    <= ld[7];
                    if (is_rst) for (int i = 0; i < 10; i++) regs[i] <= dflt(i);
                end
                DATA: if (rise) begin
                    shreg   <= byte_in;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (!rd && !is_nop) begin
                            regs[addr] <= byte_in;
                            RegWrite   <= 1'b1;
                            RegAddr    <= addr;
                            RegWData   <= byte_in;
                        end
                        addr <= addr + 4'd1;
                        left <= left - 3'd1;
                    end
                end else if (fall) begin
                    // bit_cnt wrapped to 0 means a byte just completed: fetch the next one.
                    if (bit_cnt == 3'd0) begin
                        oshift <= ld;
                        SPIDo  <= ld[7];
                    end else begin
                        oshift <= {oshift[6:0], 1'b1};
                        SPIDo  <= oshift[6];
                    end
                end
                default: ;
            endcase
            if (state_nxt == IDLE) begin
                MCUReady <= 1'b1;
                bit_cnt  <= 3'd0;
            end
            if (state_nxt == IDLE || state_nxt == DONE || state_nxt == IGNORE) SPIDo <= 1'b1;
        end
    end
endmodule
